// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-register bridge: state encoding,
// command/address field layout and the default idle byte.
package spi_bridge_pkg;

    localparam int ADDR_W     = 7;
    localparam int CMD_RD_BIT = 7;
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } bridge_state_t;

    // Address arithmetic wraps naturally at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic              inc);
        return addr + {{(ADDR_W-1){1'b0}}, inc};
    endfunction

endpackage

// File: rtl/spi_reg_bridge_sync2.sv
// Two-flop synchronizer used to bring the raw SPI chip select into the clk domain.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Bridges a byte-oriented SPI slave onto a simple register bus: first byte of a
// frame is the command (bit 7 = read, bits 6:0 = address), following bytes are data.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
    parameter bit         AUTO_INC  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ssel,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic [7:0]        frame_cnt
);

    logic              ssel_sync;
    logic              frame_active;
    logic              frame_active_d;
    logic              frame_fall;
    logic [1:0]        settle_cnt;
    logic              seen_idle;

    bridge_state_t     state;
    bridge_state_t     state_next;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] reg_addr_next;
    logic [7:0]        wdata_next;
    logic [7:0]        tx_next;
    logic              we_next;
    logic              re_next;
    logic              rd_pend;
    logic              count_frame;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_ssel_sync (
        .clk (clk),
        .rst (rst),
        .d   (ssel),
        .q   (ssel_sync)
    );

    assign frame_active = ~ssel_sync;
    assign frame_fall   = frame_active_d & ~frame_active;

    // A frame may only start once the synchronizer has settled and shown a
    // deselected bus, so a reset released mid-frame waits for a fresh select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_active_d <= 1'b0;
            settle_cnt     <= 2'd0;
            seen_idle      <= 1'b0;
        end else begin
            frame_active_d <= frame_active;
            if (settle_cnt != 2'd2) begin
                settle_cnt <= settle_cnt + 2'd1;
            end else if (!frame_active) begin
                seen_idle <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        addr_next     = addr;
        reg_addr_next = reg_addr;
        wdata_next    = reg_wdata;
        tx_next       = tx_data;
        we_next       = 1'b0;
        re_next       = 1'b0;
        count_frame   = 1'b0;

        case (state)
            IDLE: begin
                tx_next = IDLE_BYTE;
                if (frame_active && seen_idle) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (rx_rdy) begin
                    addr_next     = rx_data[ADDR_W-1:0];
                    reg_addr_next = rx_data[ADDR_W-1:0];
                    re_next       = rx_data[CMD_RD_BIT];
                    state_next    = rx_data[CMD_RD_BIT] ? RD : WR;
                end
            end
            WR: begin
                if (rx_rdy) begin
                    we_next       = 1'b1;
                    wdata_next    = rx_data;
                    reg_addr_next = addr;
                    addr_next     = next_addr(addr, AUTO_INC);
                end
            end
            RD: begin
                // Each received byte prefetches the next register for the following byte.
                if (rd_pend) begin
                    tx_next = reg_rdata;
                end
                if (rx_rdy) begin
                    addr_next     = next_addr(addr, AUTO_INC);
                    reg_addr_next = next_addr(addr, AUTO_INC);
                    re_next       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A byte arriving with the deselect is still processed above; only the state returns home.
        if (frame_fall) begin
            state_next  = IDLE;
            tx_next     = IDLE_BYTE;
            count_frame = (state == WR) || (state == RD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr      <= '0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            rd_pend   <= 1'b0;
            tx_data   <= IDLE_BYTE;
            frame_cnt <= 8'h00;
        end else begin
            addr      <= addr_next;
            reg_addr  <= reg_addr_next;
            reg_wdata <= wdata_next;
            reg_we    <= we_next;
            reg_re    <= re_next;
            rd_pend   <= reg_re;
            tx_data   <= tx_next;
            if (count_frame) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: byte-level SPI frames, a register model,
// and a second instance with address auto-increment disabled.
module tb_spi_reg_bridge;
    import spi_bridge_pkg::*;

    logic       clk;
    logic       rst;
    logic       ssel;
    logic [7:0] rx_data;
    logic       rx_rdy;

    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic [7:0] frame_cnt;

    logic [7:0] tx_data_h;
    logic [6:0] reg_addr_h;
    logic [7:0] reg_wdata_h;
    logic       reg_we_h;
    logic       reg_re_h;
    logic [7:0] reg_rdata_h;
    logic [7:0] frame_cnt_h;

    int vectors;
    int miscompares;

    logic [7:0] mem [128];
    logic [6:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int overlap_cnt;
    int re_cnt;
    int hold_re_cnt;
    int hold_re_bad;

    logic [7:0] m0, m1, m2, unused_miso;

    spi_reg_bridge u_dut (
        .clk       (clk),
        .rst       (rst),
        .ssel      (ssel),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_cnt (frame_cnt)
    );

    spi_reg_bridge #(
        .AUTO_INC (1'b0)
    ) u_dut_hold (
        .clk       (clk),
        .rst       (rst),
        .ssel      (ssel),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .tx_data   (tx_data_h),
        .reg_addr  (reg_addr_h),
        .reg_wdata (reg_wdata_h),
        .reg_we    (reg_we_h),
        .reg_re    (reg_re_h),
        .reg_rdata (reg_rdata_h),
        .frame_cnt (frame_cnt_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign reg_rdata_h = 8'h00;

    // Register model: read data appears one clk after the read strobe.
    initial reg_rdata = 8'h00;
    always @(posedge clk) begin
        if (reg_re) begin
            reg_rdata <= mem[reg_addr];
        end
    end

    always @(negedge clk) begin
        if (reg_we) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_we && reg_re) overlap_cnt++;
        if (reg_re) re_cnt++;
        if (reg_re_h) begin
            hold_re_cnt++;
            if (reg_addr_h !== 7'h05) hold_re_bad++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic start_frame();
        #1 ssel = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        repeat (4) @(posedge clk);
        #1 ssel = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // One SPI byte: the slave loads tx_data at the start of the byte, then reports rx_rdy.
    task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
        repeat (6) @(posedge clk);
        #1 miso = tx_data;
        repeat (8) @(posedge clk);
        #1;
        rx_data = mosi;
        rx_rdy  = 1'b1;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        overlap_cnt = 0;
        re_cnt      = 0;
        hold_re_cnt = 0;
        hold_re_bad = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[7'h20] = 8'h11;
        mem[7'h21] = 8'h22;

        rst     = 1'b0;
        ssel    = 1'b1;
        rx_data = 8'h00;
        rx_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset tx_data",   32'(tx_data),   32'h0A5);
        check_output("reset reg_addr",  32'(reg_addr),  32'h0);
        check_output("reset reg_wdata", 32'(reg_wdata), 32'h0);
        check_output("reset reg_we",    32'(reg_we),    32'h0);
        check_output("reset reg_re",    32'(reg_re),    32'h0);
        check_output("reset frame_cnt", 32'(frame_cnt), 32'h0);
        check_output("reset state",     32'(u_dut.state), 32'(IDLE));
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] write two bytes at 0x10");
        clear_writes();
        start_frame();
        spi_byte(8'h10, unused_miso);
        spi_byte(8'h3C, unused_miso);
        spi_byte(8'h5A, unused_miso);
        end_frame();
        check_output("wr count",     32'(wr_addr_q.size()), 32'd2);
        check_output("wr0 addr",     32'(wr_addr_q[0]), 32'h10);
        check_output("wr0 data",     32'(wr_data_q[0]), 32'h3C);
        check_output("wr1 addr",     32'(wr_addr_q[1]), 32'h11);
        check_output("wr1 data",     32'(wr_data_q[1]), 32'h5A);
        check_output("wr frame_cnt", 32'(frame_cnt), 32'd1);

        $display("[TB] read at 0x20");
        start_frame();
        spi_byte(8'hA0, m0);
        spi_byte(8'h00, m1);
        spi_byte(8'h00, m2);
        end_frame();
        check_output("rd miso0",     32'(m0), 32'hA5);
        check_output("rd miso1",     32'(m1), 32'h11);
        check_output("rd miso2",     32'(m2), 32'h22);
        check_output("rd tx idle",   32'(tx_data), 32'hA5);
        check_output("rd frame_cnt", 32'(frame_cnt), 32'd2);

        $display("[TB] address wrap");
        clear_writes();
        start_frame();
        spi_byte(8'h7F, unused_miso);
        spi_byte(8'h01, unused_miso);
        spi_byte(8'h02, unused_miso);
        end_frame();
        check_output("wrap count", 32'(wr_addr_q.size()), 32'd2);
        check_output("wrap addr0", 32'(wr_addr_q[0]), 32'h7F);
        check_output("wrap data0", 32'(wr_data_q[0]), 32'h01);
        check_output("wrap addr1", 32'(wr_addr_q[1]), 32'h00);
        check_output("wrap data1", 32'(wr_data_q[1]), 32'h02);

        $display("[TB] held address read");
        hold_re_cnt = 0;
        hold_re_bad = 0;
        start_frame();
        spi_byte(8'h85, unused_miso);
        spi_byte(8'h00, unused_miso);
        spi_byte(8'h00, unused_miso);
        spi_byte(8'h00, unused_miso);
        end_frame();
        // Command byte prefetch plus one prefetch per dummy byte.
        check_output("hold re count",  32'(hold_re_cnt), 32'd4);
        check_output("hold re badaddr", 32'(hold_re_bad), 32'd0);
        check_output("hold frame_cnt", 32'(frame_cnt_h), 32'd4);
        check_output("main frame_cnt", 32'(frame_cnt), 32'd4);

        $display("[TB] abort during data byte");
        clear_writes();
        start_frame();
        spi_byte(8'h30, unused_miso);
        repeat (8) @(posedge clk);
        #1;
        end_frame();
        check_output("abort writes",    32'(wr_addr_q.size()), 32'd0);
        check_output("abort state",     32'(u_dut.state), 32'(IDLE));
        check_output("abort tx_data",   32'(tx_data), 32'hA5);
        check_output("abort reg_we",    32'(reg_we), 32'd0);
        check_output("abort frame_cnt", 32'(frame_cnt), 32'd5);

        $display("[TB] frame without a complete command byte");
        start_frame();
        repeat (6) @(posedge clk);
        #1;
        end_frame();
        check_output("empty frame_cnt", 32'(frame_cnt), 32'd5);

        $display("[TB] byte coincident with deselect");
        clear_writes();
        start_frame();
        spi_byte(8'h50, unused_miso);
        repeat (5) @(posedge clk);
        #1 ssel = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        check_output("late reg_we",    32'(reg_we), 32'd1);
        check_output("late reg_addr",  32'(reg_addr), 32'h50);
        check_output("late reg_wdata", 32'(reg_wdata), 32'h77);
        check_output("late state",     32'(u_dut.state), 32'(IDLE));
        check_output("late frame_cnt", 32'(frame_cnt), 32'd6);
        @(posedge clk);
        #1;
        check_output("late we single", 32'(reg_we), 32'd0);
        check_output("late wr count",  32'(wr_addr_q.size()), 32'd1);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] reset during read frame");
        start_frame();
        spi_byte(8'hA0, unused_miso);
        spi_byte(8'h00, unused_miso);
        #1 rst = 1'b0;
        #1;
        check_output("mid rst tx_data",   32'(tx_data), 32'hA5);
        check_output("mid rst reg_re",    32'(reg_re), 32'd0);
        check_output("mid rst reg_addr",  32'(reg_addr), 32'h0);
        check_output("mid rst frame_cnt", 32'(frame_cnt), 32'd0);
        check_output("mid rst state",     32'(u_dut.state), 32'(IDLE));
        check_output("mid rst hold wdata", 32'(reg_wdata_h), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        re_cnt = 0;
        spi_byte(8'hA0, unused_miso);
        repeat (4) @(posedge clk);
        #1;
        check_output("stale select state", 32'(u_dut.state), 32'(IDLE));
        check_output("stale select re",    32'(re_cnt), 32'd0);
        end_frame();

        start_frame();
        spi_byte(8'hA0, m0);
        spi_byte(8'h00, m1);
        spi_byte(8'h00, m2);
        end_frame();
        check_output("post rst miso0",     32'(m0), 32'hA5);
        check_output("post rst miso1",     32'(m1), 32'h11);
        check_output("post rst miso2",     32'(m2), 32'h22);
        check_output("post rst frame_cnt", 32'(frame_cnt), 32'd1);
        check_output("hold tx idle",       32'(tx_data_h), 32'hA5);
        check_output("we/re overlap",      32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
